// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_pkg
// Description : Shared widths, defaults and types for the writeback arbiter.
//               c_DSIZE / c_ASIZE / c_NREG mirror the register-file geometry;
//               c_WB_DEPTH / c_WB_STARVE are the arbiter parameter defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_arbiter_pkg;

    localparam int c_DSIZE     = 16;
    localparam int c_ASIZE     = 4;
    localparam int c_NREG      = 16;
    localparam int c_WB_DEPTH  = 2;
    localparam int c_WB_STARVE = 4;

    // Source chosen for the single register-file write port this cycle.
    typedef enum logic [1:0] {
        SEL_IDLE = 2'd0,
        SEL_PIPE = 2'd1,
        SEL_MDU  = 2'd2
    } wb_sel_e;

endpackage : wb_arbiter_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : DEPTH-entry queue of {waddr, wdata} MDU results. Provides the
//               occupancy count, head entry, and a per-entry address compare
//               used by decode to detect registers with results still queued.
// Ports       : clk, rst_n        - clock / async active-low reset
//               push, push_waddr, push_wdata - enqueue (ignored when full)
//               pop               - dequeue head (ignored when empty)
//               head_waddr, head_wdata - current head entry
//               count             - registered occupancy
//               q_addr, q_hit     - address query / combinational hit
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 4,
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [ASIZE-1:0] push_waddr,
    input  logic [DSIZE-1:0] push_wdata,
    input  logic             pop,
    output logic [ASIZE-1:0] head_waddr,
    output logic [DSIZE-1:0] head_wdata,
    output logic [CW-1:0]    count,
    input  logic [ASIZE-1:0] q_addr,
    output logic             q_hit
);

    localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

    logic [ASIZE-1:0] r_addr [DEPTH];
    logic [DSIZE-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic w_push;
    logic w_pop;
    logic w_hit;

    // Guard against illegal requests so the pointers can never desynchronise
    // from the count.
    assign w_push = push && (r_count < c_FULL);
    assign w_pop  = pop  && (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
            r_vld   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            // Push and pop never target the same slot: a push needs a free
            // slot and a pop needs an occupied one.
            if (w_push) begin
                r_addr[r_wptr] <= push_waddr;
                r_data[r_wptr] <= push_wdata;
                r_vld[r_wptr]  <= 1'b1;
                r_wptr         <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Compare against registered entries only: an entry being popped still
    // hits this cycle, one being pushed does not hit until next cycle.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_addr[i] == q_addr)) begin
                w_hit = 1'b1;
            end
        end
    end

    assign q_hit      = w_hit && (q_addr != '0);
    assign head_waddr = r_addr[r_rptr];
    assign head_wdata = r_data[r_rptr];
    assign count      = r_count;

endmodule : wb_fifo
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Writeback arbiter for the register file's single write port.
//               The in-order pipeline has priority; out-of-order MDU results
//               wait in a small queue. Once the pipeline has won STARVE_MAX
//               consecutive cycles with MDU work pending, the queue head is
//               forced through and the pipeline is stalled for that cycle.
// Ports       : clk, rst_n                     - clock / async active-low reset
//               pipe_valid/waddr/wdata         - pipeline writeback
//               stall_req                      - pipeline must hold its entry
//               mdu_valid/ready/waddr/wdata    - MDU result handshake
//               q_addr, q_hit                  - decode pending-result query
//               rf_wen, rf_waddr, rf_wdata     - registered register-file write
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DSIZE      = c_DSIZE,
    parameter int ASIZE      = c_ASIZE,
    parameter int DEPTH      = c_WB_DEPTH,
    parameter int STARVE_MAX = c_WB_STARVE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pipe_valid,
    input  logic [ASIZE-1:0] pipe_waddr,
    input  logic [DSIZE-1:0] pipe_wdata,
    output logic             stall_req,
    input  logic             mdu_valid,
    output logic             mdu_ready,
    input  logic [ASIZE-1:0] mdu_waddr,
    input  logic [DSIZE-1:0] mdu_wdata,
    input  logic [ASIZE-1:0] q_addr,
    output logic             q_hit,
    output logic             rf_wen,
    output logic [ASIZE-1:0] rf_waddr,
    output logic [DSIZE-1:0] rf_wdata
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    localparam logic [CW-1:0] c_FULL       = CW'(DEPTH);
    localparam logic [SW-1:0] c_STARVE_LIM = SW'(STARVE_MAX);

    logic [CW-1:0]    w_count;
    logic [ASIZE-1:0] w_head_waddr;
    logic [DSIZE-1:0] w_head_wdata;
    logic             w_nonempty;
    logic             w_force;
    logic             w_push;
    logic             w_pop;
    wb_sel_e          w_sel;
    logic [ASIZE-1:0] w_sel_waddr;
    logic [DSIZE-1:0] w_sel_wdata;
    logic             w_write;

    logic [SW-1:0]    r_starve;
    logic             r_wen;
    logic [ASIZE-1:0] r_waddr;
    logic [DSIZE-1:0] r_wdata;

    wb_fifo #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_push),
        .push_waddr (mdu_waddr),
        .push_wdata (mdu_wdata),
        .pop        (w_pop),
        .head_waddr (w_head_waddr),
        .head_wdata (w_head_wdata),
        .count      (w_count),
        .q_addr     (q_addr),
        .q_hit      (q_hit)
    );

    assign w_nonempty = (w_count != '0);
    assign w_force    = (r_starve == c_STARVE_LIM) && w_nonempty;

    // Readiness comes from the registered count only, so a full queue never
    // accepts even when its head drains in the same cycle.
    assign mdu_ready  = (w_count < c_FULL);
    assign w_push     = mdu_valid && mdu_ready;

    always_comb begin
        w_sel = SEL_IDLE;
        if (w_force) begin
            w_sel = SEL_MDU;
        end else if (pipe_valid) begin
            w_sel = SEL_PIPE;
        end else if (w_nonempty) begin
            w_sel = SEL_MDU;
        end
    end

    assign w_pop       = (w_sel == SEL_MDU);
    assign stall_req   = w_force && pipe_valid;
    assign w_sel_waddr = (w_sel == SEL_MDU) ? w_head_waddr : pipe_waddr;
    assign w_sel_wdata = (w_sel == SEL_MDU) ? w_head_wdata : pipe_wdata;

    // Writes to r0 are consumed but never reach the register file.
    assign w_write     = (w_sel != SEL_IDLE) && (w_sel_waddr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (!w_nonempty || w_pop) begin
            r_starve <= '0;
        end else if ((w_sel == SEL_PIPE) && (r_starve != c_STARVE_LIM)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_wen <= w_write;
            if (w_write) begin
                r_waddr <= w_sel_waddr;
                r_wdata <= w_sel_wdata;
            end
        end
    end

    assign rf_wen   = r_wen;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;

endmodule : wb_arbiter
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Self-checking bench for wb_arbiter. A queue-based reference
//               model tracks pending MDU results and the starvation count;
//               directed scenarios are followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_valid = 1'b0;
    logic [3:0]  pipe_waddr = '0;
    logic [15:0] pipe_wdata = '0;
    logic        stall_req;
    logic        mdu_valid = 1'b0;
    logic        mdu_ready;
    logic [3:0]  mdu_waddr = '0;
    logic [15:0] mdu_wdata = '0;
    logic [3:0]  q_addr = '0;
    logic        q_hit;
    logic        rf_wen;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;

    wb_arbiter #(
        .DSIZE      (16),
        .ASIZE      (4),
        .DEPTH      (DEPTH),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pipe_valid (pipe_valid),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .stall_req  (stall_req),
        .mdu_valid  (mdu_valid),
        .mdu_ready  (mdu_ready),
        .mdu_waddr  (mdu_waddr),
        .mdu_wdata  (mdu_wdata),
        .q_addr     (q_addr),
        .q_hit      (q_hit),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model state: pending MDU results in arrival order.
    logic [19:0] mq[$];
    int          starve = 0;
    logic        m_wen = 1'b0;
    logic [3:0]  m_waddr = '0;
    logic [15:0] m_wdata = '0;
    logic        last_stall = 1'b0;
    logic        last_accept = 1'b0;
    int          stall_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        starve  = 0;
        m_wen   = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    // One clock cycle: drive inputs, check combinational outputs against the
    // model, advance the model by the arbitration rules, check registered
    // outputs after the edge.
    task automatic cycle(input logic pv, input logic [3:0] pa, input logic [15:0] pd,
                         input logic mv, input logic [3:0] ma, input logic [15:0] md,
                         input logic [3:0] qa);
        logic        frc;
        logic        hit;
        logic        sel_v;
        logic [19:0] sel;
        int          n;
        pipe_valid = pv; pipe_waddr = pa; pipe_wdata = pd;
        mdu_valid  = mv; mdu_waddr  = ma; mdu_wdata  = md;
        q_addr     = qa;
        #1;
        n   = mq.size();
        frc = (starve == SMAX) && (n != 0);
        hit = 1'b0;
        foreach (mq[i]) if (mq[i][19:16] == qa) hit = 1'b1;
        hit = hit && (qa != 4'd0);
        chk("mdu_ready", {31'd0, mdu_ready}, {31'd0, n < DEPTH});
        chk("stall_req", {31'd0, stall_req}, {31'd0, frc && pv});
        chk("q_hit",     {31'd0, q_hit},     {31'd0, hit});
        last_accept = mv && (n < DEPTH);
        last_stall  = frc && pv;
        if (last_stall) stall_cnt++;
        sel_v = 1'b0;
        sel   = '0;
        if (frc) begin
            sel = mq.pop_front(); sel_v = 1'b1; starve = 0;
        end else if (pv) begin
            sel = {pa, pd}; sel_v = 1'b1;
            if (n != 0 && starve < SMAX) starve++;
        end else if (n != 0) begin
            sel = mq.pop_front(); sel_v = 1'b1; starve = 0;
        end
        if (n == 0) starve = 0;
        if (last_accept) mq.push_back({ma, md});
        if (sel_v && sel[19:16] != 4'd0) begin
            m_wen = 1'b1; m_waddr = sel[19:16]; m_wdata = sel[15:0];
        end else begin
            m_wen = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("rf_wen",   {31'd0, rf_wen},   {31'd0, m_wen});
        chk("rf_waddr", {28'd0, rf_waddr}, {28'd0, m_waddr});
        chk("rf_wdata", {16'd0, rf_wdata}, {16'd0, m_wdata});
    endtask

    initial begin
        logic        pv;
        logic [3:0]  pa;
        logic [15:0] pd;
        logic        mv;
        logic [3:0]  ma;
        logic [15:0] md;

        // Reset values
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wen",   {31'd0, rf_wen},    32'd0);
        chk("rst_waddr", {28'd0, rf_waddr},  32'd0);
        chk("rst_wdata", {16'd0, rf_wdata},  32'd0);
        chk("rst_ready", {31'd0, mdu_ready}, 32'd1);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Pipeline only: r3 = 0x1234 written on the next edge
        cycle(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0, 4'd3);
        chk("pipe_only_addr", {28'd0, rf_waddr}, 32'd3);
        chk("pipe_only_data", {16'd0, rf_wdata}, 32'h1234);

        // MDU idle path: accept, hit next cycle, write two edges after accept
        cycle(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 16'h00FF, 4'd5);
        cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0,    4'd5);
        chk("mdu_path_addr", {28'd0, rf_waddr}, 32'd5);
        chk("mdu_path_data", {16'd0, rf_wdata}, 32'h00FF);
        cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd5);

        // Full queue with the pipeline held busy; third offer waits
        cycle(1'b1, 4'd1, 16'h1111, 1'b1, 4'd6, 16'h0606, 4'd6);
        cycle(1'b1, 4'd2, 16'h2222, 1'b1, 4'd7, 16'h0707, 4'd7);
        pa = 4'd3; pd = 16'h3333;
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, pa, pd, 1'b1, 4'd8, 16'h0808, 4'd8);
            if (last_accept) break;
            if (!last_stall) begin pa = pa + 4'd1; pd = pd + 16'h1111; end
        end
        chk("full_third_accepted", {31'd0, last_accept}, 32'd1);
        repeat (4) cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd8);

        // Starvation: one queued entry vs a continuous pipeline stream
        stall_cnt = 0;
        cycle(1'b1, 4'd9, 16'h9000, 1'b1, 4'd10, 16'hA0A0, 4'd10);
        pa = 4'd11; pd = 16'h9001;
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, pa, pd, 1'b0, 4'd0, 16'h0, 4'd10);
            if (k == 4) begin
                chk("starve_mdu_addr", {28'd0, rf_waddr}, 32'd10);
                chk("starve_mdu_data", {16'd0, rf_wdata}, 32'hA0A0);
            end
            if (!last_stall) begin pa = (pa == 4'd15) ? 4'd1 : pa + 4'd1; pd = pd + 16'd1; end
        end
        chk("starve_stall_count", stall_cnt, 32'd1);

        // Register 0: popped but never written
        cycle(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 16'hDEAD, 4'd0);
        cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0,    4'd0);
        chk("r0_no_wen", {31'd0, rf_wen}, 32'd0);
        cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd0);

        // Async reset with two entries queued and rf_wen high
        cycle(1'b1, 4'd4, 16'h4444, 1'b1, 4'd12, 16'hC0C0, 4'd12);
        cycle(1'b1, 4'd5, 16'h5555, 1'b1, 4'd13, 16'hD0D0, 4'd12);
        pipe_valid = 1'b0; mdu_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_wen",   {31'd0, rf_wen},   32'd0);
        chk("arst_waddr", {28'd0, rf_waddr}, 32'd0);
        chk("arst_wdata", {16'd0, rf_wdata}, 32'd0);
        chk("arst_q_hit", {31'd0, q_hit},    32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 4'd14, 16'hE0E0, 1'b0, 4'd0, 16'h0, 4'd13);

        // Randomized traffic: stalled pipeline entries and unaccepted MDU
        // offers are held until consumed.
        pv = 1'b0; pa = '0; pd = '0; mv = 1'b0; ma = '0; md = '0;
        last_stall = 1'b0; last_accept = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!last_stall) begin
                pv = ($urandom_range(0, 99) < 60);
                pa = 4'($urandom_range(0, 15));
                pd = 16'($urandom);
            end
            if (!mv || last_accept) begin
                mv = ($urandom_range(0, 99) < 40);
                ma = 4'($urandom_range(0, 15));
                md = 16'($urandom);
            end
            cycle(pv, pa, pd, mv, ma, md, 4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_wb_arbiter
`default_nettype wire
